store_checker: RTL and testbench
================================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 SHALL have parameter AW, default 32, meaning data-address width.
REQ-002 SHALL have parameter DW, default 32, meaning write-data width, DW >= 16.
REQ-003 SHALL have parameter DEPTH, default 8, meaning number of expected-store entries, a power of two >= 2.
REQ-004 SHALL have parameter TMO, default 1024, meaning the timeout in cycles.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic samples on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port memwrite, input, 2 bits: store size observed (00 none, 01 byte, 10 half, 11 word).
REQ-008 SHALL have port dataadr, input, AW bits: store address.
REQ-009 SHALL have port writedata, input, DW bits: store data.
REQ-010 SHALL have port exp_push, input, 1 bit: load one expected entry.
REQ-011 SHALL have ports exp_size, exp_addr and exp_data, inputs of 2, AW and DW bits: the expected entry's size, address and data.
REQ-012 SHALL have port start, input, 1 bit: arm the checker.
REQ-013 SHALL have port done, output, 1 bit: verdict reached.
REQ-014 SHALL have ports pass, fail and timeout, outputs, 1 bit each: verdict flags.
REQ-015 SHALL have port err_idx, output, clog2(DEPTH) bits: index of the first mismatching entry.
REQ-016 SHALL have port match_cnt, output, clog2(DEPTH)+1 bits: number of in-order matches so far.

Function
REQ-017 SHALL implement FSM states IDLE, ARMED, PASS, FAIL, TMOUT.
REQ-018 In IDLE, each exp_push SHALL write the entry at the load pointer and increment it; a push when loaded count == DEPTH SHALL be ignored.
REQ-019 A push in any state other than IDLE SHALL be ignored.
REQ-020 In IDLE, start with loaded count > 0 SHALL enter ARMED next cycle and clear match_cnt, the compare pointer and the timer.
REQ-021 start with loaded count == 0 SHALL go directly to PASS.
REQ-022 In ARMED, each cycle with memwrite != 00 SHALL compare against the entry at the compare pointer: sizes equal, addresses equal, and data equal on writedata[7:0] for byte, [15:0] for half, and full DW for word.
REQ-023 On a match, match_cnt and the pointer SHALL increment; when the pointer reaches the loaded count, the next state SHALL be PASS.
REQ-024 On a mismatch, err_idx SHALL capture the pointer and the next state SHALL be FAIL.
REQ-025 Verdict latency SHALL be one cycle: done, pass and fail are registered and assert in the cycle after the deciding store.
REQ-026 PASS, FAIL and TMOUT SHALL hold with done=1 until start, which SHALL re-arm with the same table and return to ARMED.
REQ-027 Any store observed in a terminal state SHALL be ignored.
REQ-028 Exactly one of pass, fail or timeout SHALL be high whenever done=1, and all three SHALL be low otherwise.
REQ-029 start asserted while ARMED SHALL restart the check: pointer, match_cnt and timer cleared; the table is kept.
REQ-030 An X or Z on memwrite while ARMED SHALL be treated as a mismatch.

Reset
REQ-031 reset SHALL take precedence over every other input.
REQ-032 reset SHALL force the state to IDLE, the load and compare pointers to 0, match_cnt to 0, err_idx to 0, and done, pass, fail and timeout to 0.
REQ-033 Table contents SHALL be don't-care after reset; reset asserted mid-check SHALL abort the check with no verdict.

Configuration
REQ-034 Macro STORE_CHECKER_TIMEOUT_EN SHALL control the timeout feature.
REQ-035 With the macro defined, a timer SHALL count ARMED cycles since the last match or start; on reaching TMO-1 without a verdict, the next state SHALL be TMOUT, with timeout=1, done=1 and err_idx equal to the pointer.
REQ-036 Without the macro, the timer and the TMOUT state SHALL be absent, timeout SHALL be tied to 0, and ARMED SHALL wait indefinitely.

Verification
REQ-037 Push {11, 84, FFFF7F02}, start, then store word 84/FFFF7F02 -> pass=1, done=1 one cycle later, match_cnt=1.
REQ-038 Push {11, 84, FFFF7F02}, start, then store word 80/FFFF7F02 -> fail=1, err_idx=0, match_cnt=0.
REQ-039 Push a byte entry {01, 10, 000000AB}, start, then store byte at 10 with data 123456AB -> pass (upper bytes masked).
REQ-040 Push DEPTH+1 entries, then start and DEPTH matching stores -> the extra push is dropped and pass occurs after exactly DEPTH stores.
REQ-041 Macro defined, TMO=16: push one entry, start, no stores -> timeout=1 exactly 16 cycles after ARMED; macro undefined -> still ARMED after 100 cycles.
REQ-042 With 3 entries loaded, apply reset after 2 matches -> all outputs 0 and state IDLE; reload and re-run -> pass.

Source files
------------

// File: rtl/store_checker.sv
// store_checker: compares observed stores against a preloaded table of
// expected stores, in order, and reports pass / fail / timeout.
// Optional feature macro: STORE_CHECKER_TIMEOUT_EN (ARMED-state watchdog).
module store_checker #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TMO   = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    input  logic                     exp_push,
    input  logic [1:0]               exp_size,
    input  logic [AW-1:0]            exp_addr,
    input  logic [DW-1:0]            exp_data,
    input  logic                     start,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [$clog2(DEPTH)-1:0] err_idx,
    output logic [$clog2(DEPTH):0]   match_cnt
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

`ifdef STORE_CHECKER_TIMEOUT_EN
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PASS  = 3'd2,
        S_FAIL  = 3'd3,
        S_TMOUT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_PASS  = 3'd2,
        S_FAIL  = 3'd3
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [CW-1:0] cptr_q, cptr_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic [IW-1:0] err_q, err_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
`ifdef STORE_CHECKER_TIMEOUT_EN
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
`endif

    logic          tab_we_c;
    logic [IW-1:0] cidx_c;
    logic          data_ok_c;
    logic          hit_c;

    logic [1:0]    tab_size_q [DEPTH];
    logic [AW-1:0] tab_addr_q [DEPTH];
    logic [DW-1:0] tab_data_q [DEPTH];

    // Expected-store table; contents are not reset.
    always_ff @(posedge clk) begin
        if (tab_we_c) begin
            tab_size_q[lcnt_q[IW-1:0]] <= exp_size;
            tab_addr_q[lcnt_q[IW-1:0]] <= exp_addr;
            tab_data_q[lcnt_q[IW-1:0]] <= exp_data;
        end
    end

    // Compare the observed store with the entry at the compare pointer.
    // An unknown memwrite falls into the default arm and never hits.
    always_comb begin
        cidx_c    = cptr_q[IW-1:0];
        data_ok_c = 1'b0;
        case (memwrite)
            2'b01:   data_ok_c = (writedata[7:0]  == tab_data_q[cidx_c][7:0]);
            2'b10:   data_ok_c = (writedata[15:0] == tab_data_q[cidx_c][15:0]);
            2'b11:   data_ok_c = (writedata       == tab_data_q[cidx_c]);
            default: data_ok_c = 1'b0;
        endcase
        hit_c = (memwrite == tab_size_q[cidx_c]) &&
                (dataadr  == tab_addr_q[cidx_c]) && data_ok_c;
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lcnt_q    <= '0;
            cptr_q    <= '0;
            mcnt_q    <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
`ifdef STORE_CHECKER_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            cptr_q    <= cptr_d;
            mcnt_q    <= mcnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
`ifdef STORE_CHECKER_TIMEOUT_EN
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state and datapath: table loading, arming, in-order compare.
    always_comb begin
        state_d  = state_q;
        lcnt_d   = lcnt_q;
        cptr_d   = cptr_q;
        mcnt_d   = mcnt_q;
        err_d    = err_q;
        tab_we_c = 1'b0;
`ifdef STORE_CHECKER_TIMEOUT_EN
        timer_d  = timer_q;
`endif

        // Loading is only possible in IDLE and stops once the table is full.
        if (!reset && state_q == S_IDLE && exp_push && lcnt_q != CW'(DEPTH)) begin
            tab_we_c = 1'b1;
            lcnt_d   = lcnt_q + CW'(1);
        end

        // start (re)arms from any state and always keeps the table.
        if (start) begin
            cptr_d  = '0;
            mcnt_d  = '0;
            err_d   = '0;
`ifdef STORE_CHECKER_TIMEOUT_EN
            timer_d = '0;
`endif
            state_d = (lcnt_q == '0) ? S_PASS : S_ARMED;
        end else if (state_q == S_ARMED) begin
            case (memwrite)
                2'b00: begin
`ifdef STORE_CHECKER_TIMEOUT_EN
                    if (timer_q == TW'(TMO - 1)) begin
                        state_d = S_TMOUT;
                        err_d   = cidx_c;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
`endif
                end
                default: begin
                    if (hit_c) begin
                        cptr_d = cptr_q + CW'(1);
                        mcnt_d = mcnt_q + CW'(1);
`ifdef STORE_CHECKER_TIMEOUT_EN
                        timer_d = '0;
`endif
                        if (cptr_d == lcnt_q) begin
                            state_d = S_PASS;
                        end
                    end else begin
                        state_d = S_FAIL;
                        err_d   = cidx_c;
                    end
                end
            endcase
        end
    end

    // Verdict flags follow the next state so they appear one cycle after the deciding store.
    always_comb begin
        done_d    = 1'b0;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
`ifdef STORE_CHECKER_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_d)
            S_PASS: begin
                done_d = 1'b1;
                pass_d = 1'b1;
            end
            S_FAIL: begin
                done_d = 1'b1;
                fail_d = 1'b1;
            end
`ifdef STORE_CHECKER_TIMEOUT_EN
            S_TMOUT: begin
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
`endif
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign err_idx   = err_q;
    assign match_cnt = mcnt_q;

`ifdef STORE_CHECKER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // Without the watchdog, TMO has no effect and timeout is constant.
    logic unused_tmo_c;
    assign unused_tmo_c = |TMO;
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Testbench for store_checker: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
// Define STORE_CHECKER_TIMEOUT_EN for both bench and RTL to test the watchdog.
module tb_store_checker;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int IW    = $clog2(DEPTH);
`ifdef STORE_CHECKER_TIMEOUT_EN
    localparam int TMO   = 16;
`else
    localparam int TMO   = 1024;
`endif

    logic          clk;
    logic          reset;
    logic [1:0]    memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          exp_push;
    logic [1:0]    exp_size;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          start;
    logic          done, pass, fail, timeout;
    logic [IW-1:0] err_idx;
    logic [IW:0]   match_cnt;

    store_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_push(exp_push), .exp_size(exp_size),
        .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .err_idx(err_idx), .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the expected table as plain arrays, plus the verdict.
    int            m_n;
    logic [1:0]    m_sz [DEPTH];
    logic [AW-1:0] m_ad [DEPTH];
    logic [DW-1:0] m_dt [DEPTH];
    int            m_phase;    // 0 loading, 1 checking, 2 verdict held
    int            m_verdict;  // 1 pass, 2 fail, 3 timeout
    int            m_ptr, m_mcnt, m_err, m_idle;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] size_mask(input logic [1:0] s);
        logic [DW-1:0] m;
        m = '1;
        if (s == 2'b01) m = DW'(32'h0000_00FF);
        if (s == 2'b10) m = DW'(32'h0000_FFFF);
        return m;
    endfunction

    task automatic model_step();
        int n_old;
        if (reset) begin
            m_phase = 0; m_n = 0; m_ptr = 0; m_mcnt = 0; m_err = 0;
            m_verdict = 0; m_idle = 0;
            return;
        end
        n_old = m_n;
        if (m_phase == 0 && exp_push && m_n < DEPTH) begin
            m_sz[m_n] = exp_size; m_ad[m_n] = exp_addr; m_dt[m_n] = exp_data;
            m_n++;
        end
        if (start) begin
            m_ptr = 0; m_mcnt = 0; m_err = 0; m_idle = 0;
            if (n_old == 0) begin
                m_phase = 2; m_verdict = 1;
            end else begin
                m_phase = 1; m_verdict = 0;
            end
        end else if (m_phase == 1) begin
            if (memwrite != 2'b00) begin
                if (memwrite == m_sz[m_ptr] && dataadr == m_ad[m_ptr] &&
                    ((writedata ^ m_dt[m_ptr]) & size_mask(memwrite)) == '0) begin
                    m_ptr++; m_mcnt++; m_idle = 0;
                    if (m_ptr == m_n) begin
                        m_phase = 2; m_verdict = 1;
                    end
                end else begin
                    m_phase = 2; m_verdict = 2; m_err = m_ptr;
                end
            end else begin
`ifdef STORE_CHECKER_TIMEOUT_EN
                if (m_idle == TMO - 1) begin
                    m_phase = 2; m_verdict = 3; m_err = m_ptr;
                end else begin
                    m_idle++;
                end
`endif
            end
        end
    endtask

    task automatic check_outputs();
        chk("done",      64'(done),      64'(m_phase == 2));
        chk("pass",      64'(pass),      64'(m_phase == 2 && m_verdict == 1));
        chk("fail",      64'(fail),      64'(m_phase == 2 && m_verdict == 2));
        chk("timeout",   64'(timeout),   64'(m_phase == 2 && m_verdict == 3));
        chk("match_cnt", 64'(match_cnt), 64'(m_mcnt));
        chk("err_idx",   64'(err_idx),   64'(m_err));
    endtask

    // One clock: model advances on the edge, outputs compared just after it.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_in();
        reset = 1'b0; memwrite = 2'b00; exp_push = 1'b0; start = 1'b0;
    endtask

    task automatic do_reset();
        idle_in(); reset = 1'b1; cycle();
    endtask

    task automatic nop();
        idle_in(); cycle();
    endtask

    task automatic do_start();
        idle_in(); start = 1'b1; cycle();
    endtask

    task automatic push(input logic [1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_in(); exp_push = 1'b1; exp_size = s; exp_addr = a; exp_data = d; cycle();
    endtask

    task automatic store(input logic [1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_in(); memwrite = s; dataadr = a; writedata = d; cycle();
    endtask

    initial begin
        dataadr = '0; writedata = '0; exp_size = '0; exp_addr = '0; exp_data = '0;
        do_reset();
        do_reset();
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mcnt", 64'(match_cnt), 64'd0);

        // Word store matches
        do_reset();
        push(2'b11, 32'h84, 32'hFFFF7F02);
        do_start();
        chk("w_armed_done", 64'(done), 64'd0);
        store(2'b11, 32'h84, 32'hFFFF7F02);
        chk("w_pass", 64'(pass), 64'd1);
        chk("w_done", 64'(done), 64'd1);
        chk("w_mcnt", 64'(match_cnt), 64'd1);

        // Address mismatch
        do_reset();
        push(2'b11, 32'h84, 32'hFFFF7F02);
        do_start();
        store(2'b11, 32'h80, 32'hFFFF7F02);
        chk("a_fail", 64'(fail), 64'd1);
        chk("a_err", 64'(err_idx), 64'd0);
        chk("a_mcnt", 64'(match_cnt), 64'd0);

        // Byte store with upper bytes masked; verdict holds; re-arm
        do_reset();
        push(2'b01, 32'h10, 32'h000000AB);
        do_start();
        store(2'b01, 32'h10, 32'h123456AB);
        chk("b_pass", 64'(pass), 64'd1);
        store(2'b11, 32'h44, 32'h0);
        nop();
        chk("b_hold", 64'(pass), 64'd1);
        do_start();
        chk("b_rearm_done", 64'(done), 64'd0);
        store(2'b01, 32'h10, 32'hFFFFFFAB);
        chk("b_rearm_pass", 64'(pass), 64'd1);

        // Overfilled table: extra push dropped
        do_reset();
        for (int i = 0; i <= DEPTH; i++) push(2'b11, AW'(4 * i), DW'(32'hA000_0000 + i));
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("full_not_yet", 64'(done), 64'd0);
            store(2'b11, AW'(4 * i), DW'(32'hA000_0000 + i));
        end
        chk("full_pass", 64'(pass), 64'd1);
        chk("full_mcnt", 64'(match_cnt), 64'(DEPTH));

        // Watchdog behaviour
        do_reset();
        push(2'b10, 32'h30, 32'h1234);
        do_start();
`ifdef STORE_CHECKER_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) nop();
        chk("tmo_early", 64'(done), 64'd0);
        nop();
        chk("tmo_flag", 64'(timeout), 64'd1);
        chk("tmo_err", 64'(err_idx), 64'd0);
`else
        for (int i = 0; i < 100; i++) nop();
        chk("notmo_wait", 64'(done), 64'd0);
        store(2'b10, 32'h30, 32'hFFFF1234);
        chk("notmo_pass", 64'(pass), 64'd1);
`endif

        // Reset mid-check, then reload and re-run
        do_reset();
        for (int i = 0; i < 3; i++) push(2'b11, AW'(32'h20 + 4 * i), DW'(i + 7));
        do_start();
        store(2'b11, 32'h20, 32'd7);
        store(2'b11, 32'h24, 32'd8);
        chk("mid_mcnt", 64'(match_cnt), 64'd2);
        do_reset();
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_mcnt0", 64'(match_cnt), 64'd0);
        for (int i = 0; i < 3; i++) push(2'b11, AW'(32'h20 + 4 * i), DW'(i + 7));
        do_start();
        for (int i = 0; i < 3; i++) store(2'b11, AW'(32'h20 + 4 * i), DW'(i + 7));
        chk("mid_rerun_pass", 64'(pass), 64'd1);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            int n;
            do_reset();
            n = $urandom_range(0, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) nop();
                push(2'($urandom_range(1, 3)), AW'({$urandom_range(0, 7), 2'b00}), DW'($urandom));
            end
            do_start();
            for (int c = 0; c < 30; c++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 55 && m_phase == 1) begin
                    logic [1:0] s;
                    s = m_sz[m_ptr];
                    store(s, m_ad[m_ptr], m_dt[m_ptr] ^ (DW'($urandom) & ~size_mask(s)));
                end else if (r < 70) begin
                    store(2'($urandom_range(1, 3)), AW'({$urandom_range(0, 7), 2'b00}), DW'($urandom));
                end else if (r < 74) begin
                    do_start();
                end else if (r < 77) begin
                    push(2'b11, AW'(32'h40), DW'($urandom));
                end else begin
                    nop();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
